// File: rtl/double_pulse_capture.sv
// Measures an asynchronous double pulse (high1, gap, high2) in sys_clk cycles.
// Optional glitch filter on the synchronized input: DOUBLE_PULSE_CAPTURE_GLITCH_FILTER_EN.
module double_pulse_capture #(
  parameter int                CNT_W       = 21,
  parameter logic [CNT_W-1:0]  TIMEOUT_CYC = 21'd2000000
`ifdef DOUBLE_PULSE_CAPTURE_GLITCH_FILTER_EN
  , parameter int              GLITCH_CYC  = 4
`endif
) (
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  input  logic             pulse_in,
  input  logic             arm,
  output logic             busy,
  output logic [CNT_W-1:0] meas_width1,
  output logic [CNT_W-1:0] meas_gap,
  output logic [CNT_W-1:0] meas_width2,
  output logic             meas_valid,
  output logic             meas_timeout
);

  typedef enum logic [2:0] {IDLE, ARMED, HIGH1, GAP, HIGH2} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [CNT_W-1:0] w1, w1_nxt, g, g_nxt;
  logic [CNT_W-1:0] width1_nxt, gap_nxt, width2_nxt;
  logic             valid_nxt, timeout_nxt;
  logic             sync_p0, sync_p1, p_s, p_d;
  logic             rise, fall, expire;

  // stage p0/p1: two-flop synchronizer
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
    end else begin
      sync_p0 <= pulse_in;
      sync_p1 <= sync_p0;
    end
  end

`ifdef DOUBLE_PULSE_CAPTURE_GLITCH_FILTER_EN
  localparam int GW = $clog2(GLITCH_CYC + 1);
  logic [GW-1:0] gcnt;
  logic          filt;

  // filtered level follows sync_p1 only after GLITCH_CYC consecutive differing cycles
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      gcnt <= '0;
      filt <= 1'b0;
    end else if (sync_p1 == filt) begin
      gcnt <= '0;
    end else if (gcnt == GW'(GLITCH_CYC - 1)) begin
      filt <= sync_p1;
      gcnt <= '0;
    end else begin
      gcnt <= gcnt + 1'b1;
    end
  end

  assign p_s = filt;
`else
  assign p_s = sync_p1;
`endif

  // stage p2: edge detect against the one-cycle delayed level
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) p_d <= 1'b0;
    else            p_d <= p_s;
  end

  assign rise   = p_s & ~p_d;
  assign fall   = ~p_s & p_d;
  assign expire = (cnt == TIMEOUT_CYC);
  assign busy   = (state != IDLE);

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    w1_nxt      = w1;
    g_nxt       = g;
    width1_nxt  = meas_width1;
    gap_nxt     = meas_gap;
    width2_nxt  = meas_width2;
    valid_nxt   = 1'b0;
    timeout_nxt = 1'b0;
    case (state)
      IDLE: begin
        // a strobe cycle is still "busy" from the requester's point of view
        if (arm && !meas_valid && !meas_timeout) state_nxt = ARMED;
      end
      ARMED: begin
        if (rise) begin
          state_nxt = HIGH1;
          cnt_nxt   = CNT_W'(1);
        end
      end
      HIGH1: begin
        if (fall) begin
          w1_nxt    = cnt;
          cnt_nxt   = CNT_W'(1);
          state_nxt = GAP;
        end else if (expire) begin
          timeout_nxt = 1'b1;
          state_nxt   = IDLE;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      GAP: begin
        if (rise) begin
          g_nxt     = cnt;
          cnt_nxt   = CNT_W'(1);
          state_nxt = HIGH2;
        end else if (expire) begin
          timeout_nxt = 1'b1;
          state_nxt   = IDLE;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      HIGH2: begin
        if (fall) begin
          width1_nxt = w1;
          gap_nxt    = g;
          width2_nxt = cnt;
          valid_nxt  = 1'b1;
          state_nxt  = IDLE;
        end else if (expire) begin
          timeout_nxt = 1'b1;
          state_nxt   = IDLE;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state        <= IDLE;
      cnt          <= '0;
      w1           <= '0;
      g            <= '0;
      meas_width1  <= '0;
      meas_gap     <= '0;
      meas_width2  <= '0;
      meas_valid   <= 1'b0;
      meas_timeout <= 1'b0;
    end else begin
      state        <= state_nxt;
      cnt          <= cnt_nxt;
      w1           <= w1_nxt;
      g            <= g_nxt;
      meas_width1  <= width1_nxt;
      meas_gap     <= gap_nxt;
      meas_width2  <= width2_nxt;
      meas_valid   <= valid_nxt;
      meas_timeout <= timeout_nxt;
    end
  end

endmodule
